// File: rtl/cmd_sequencer.sv
// rtl/cmd_sequencer.sv - turns line/op/value requests into a registered command byte stream
module cmd_sequencer #(
    parameter int          NUM_INPUTS = 8,
    parameter logic [7:0]  NOP_CMD    = 8'h0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [7:0]  req_line,
    input  logic [11:0] req_value,
    output logic [7:0]  cmd,
    output logic        busy,
    output logic        err
);

    localparam int unsigned NI = NUM_INPUTS;

    localparam logic [2:0] OP_CLEAR   = 3'd0;
    localparam logic [2:0] OP_CROSS   = 3'd1;
    localparam logic [2:0] OP_AUTO    = 3'd2;
    localparam logic [2:0] OP_VOLTAGE = 3'd3;
    localparam logic [2:0] OP_TEST    = 3'd4;
    localparam logic [2:0] OP_LEDS    = 3'd5;
    localparam logic [2:0] OP_FREQDIV = 3'd6;

    // The state names the phase of the byte currently sitting on cmd.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LINE    = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [7:0]  cmd_d;
    logic        err_d;

    // Request fields frozen at acceptance.
    logic [2:0]  op_q;
    logic [7:0]  line_q;
    logic [11:0] value_q;

    // Line chunks still to be sent after the one on cmd, and payload byte index on cmd.
    logic [3:0]  mask_q, mask_d;
    logic [1:0]  pay_q, pay_d;

    // Copy of what the decoder's current-line register holds.
    logic [7:0]  shadow_line, shadow_line_d;
    logic        shadow_valid, shadow_valid_d;

    logic        accept;
    logic [2:0]  src_op;
    logic [7:0]  src_line;
    logic [11:0] src_value;
    logic        line_op;
    logic        line_ok;
    logic [3:0]  need_mask;
    logic [3:0]  pend_mask;
    logic [3:0]  rem_mask;
    logic [1:0]  k_sel;
    logic [1:0]  pay_idx;
    logic [2:0]  pay_cnt;
    logic        pay_more;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    function automatic logic [7:0] line_byte(input logic [1:0] k, input logic [7:0] line);
        return {k, line[{k, 1'b0} +: 2], 4'h1};
    endfunction

    function automatic logic [7:0] payload_byte(input logic [2:0] op, input logic [1:0] idx,
                                                input logic [11:0] value);
        logic [2:0] dly;
        logic [7:0] b;
        case (idx)
            2'd0:    dly = value[2:0];
            2'd1:    dly = value[5:3];
            2'd2:    dly = value[8:6];
            default: dly = value[11:9];
        endcase
        case (op)
            OP_CLEAR:   b = 8'h00;
            OP_CROSS:   b = {1'b0, dly, 2'b01, idx};
            OP_AUTO:    b = {1'b1, dly, 2'b01, idx};
            OP_VOLTAGE: b = {value[3:0], 4'h9};
            OP_TEST:    b = {value[3:0], 4'hC};
            OP_LEDS:    b = {value[3:0], 4'h2};
            OP_FREQDIV: b = {value[3:0], 4'h8};
            default:    b = {3'b000, value[0], 4'hD};
        endcase
        return b;
    endfunction

    // Source fields: live inputs on the accept cycle, frozen copies afterwards.
    always_comb begin
        src_op    = op_q;
        src_line  = line_q;
        src_value = value_q;
        if (state == IDLE) begin
            src_op    = req_op;
            src_line  = req_line;
            src_value = req_value;
        end
    end

    // Chunks of the requested line the decoder does not already hold.
    always_comb begin
        need_mask = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            need_mask[k] = !shadow_valid || (shadow_line[2*k +: 2] != req_line[2*k +: 2]);
        end
    end

    // Lowest pending chunk goes out first.
    always_comb begin
        k_sel = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (pend_mask[k]) begin
                k_sel = 2'(k);
            end
        end
    end

    // Next-state and next-byte selection.
    always_comb begin
        state_d        = state;
        cmd_d          = NOP_CMD;
        err_d          = 1'b0;
        mask_d         = mask_q;
        pay_d          = pay_q;
        shadow_line_d  = shadow_line;
        shadow_valid_d = shadow_valid;

        line_op  = (src_op <= OP_LEDS);
        line_ok  = (32'(req_line) < NI);
        pay_cnt  = ((src_op == OP_CROSS) || (src_op == OP_AUTO)) ? 3'd4 : 3'd1;
        pay_idx  = (state == PAYLOAD) ? (pay_q + 2'd1) : 2'd0;
        pay_more = (state != PAYLOAD) || (({1'b0, pay_q} + 3'd1) < pay_cnt);

        case (state)
            IDLE:    pend_mask = line_op ? need_mask : 4'b0000;
            LINE:    pend_mask = mask_q;
            default: pend_mask = 4'b0000;
        endcase
        rem_mask = pend_mask & ~(4'b0001 << k_sel);

        if ((state == IDLE) && !accept) begin
            state_d = IDLE;
        end else if ((state == IDLE) && line_op && !line_ok) begin
            // Unreachable line: swallow the request and flag it.
            err_d = 1'b1;
        end else if (pend_mask != 4'b0000) begin
            state_d                            = LINE;
            cmd_d                              = line_byte(k_sel, src_line);
            mask_d                             = rem_mask;
            shadow_line_d[{k_sel, 1'b0} +: 2]  = src_line[{k_sel, 1'b0} +: 2];
            if (rem_mask == 4'b0000) begin
                shadow_valid_d = 1'b1;
            end
        end else if (pay_more) begin
            state_d = PAYLOAD;
            cmd_d   = payload_byte(src_op, pay_idx, src_value);
            pay_d   = pay_idx;
        end else begin
            state_d = IDLE;
        end
    end

    // State, output byte and shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cmd          <= NOP_CMD;
            err          <= 1'b0;
            mask_q       <= 4'b0000;
            pay_q        <= 2'd0;
            shadow_line  <= 8'h00;
            shadow_valid <= 1'b0;
        end else begin
            state        <= state_d;
            cmd          <= cmd_d;
            err          <= err_d;
            mask_q       <= mask_d;
            pay_q        <= pay_d;
            shadow_line  <= shadow_line_d;
            shadow_valid <= shadow_valid_d;
        end
    end

    // Freeze the request fields at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 3'd0;
            line_q  <= 8'h00;
            value_q <= 12'h000;
        end else if (accept) begin
            op_q    <= req_op;
            line_q  <= req_line;
            value_q <= req_value;
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// tb/tb_cmd_sequencer.sv - scoreboard bench for cmd_sequencer
module tb_cmd_sequencer;

    localparam int         NI  = 8;
    localparam logic [7:0] NOP = 8'h0F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [7:0]  req_line = 8'h00;
    logic [11:0] req_value = 12'h000;
    logic [7:0]  cmd;
    logic        busy;
    logic        err;

    cmd_sequencer #(.NUM_INPUTS(NI), .NOP_CMD(NOP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_line  (req_line),
        .req_value (req_value),
        .cmd       (cmd),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        logic [7:0] b;
    } exp_t;

    exp_t expq[$];
    int   errq[$];

    // Reference view of the decoder's current line.
    int m_line  = 0;
    bit m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_byte(input int c, input int b);
        exp_t e;
        e.cyc = c;
        e.b   = 8'(b);
        expq.push_back(e);
    endtask

    // Expected byte list for a request accepted so that its first byte shows in cycle acc.
    task automatic model(input int op, input int line, input int val, input int acc);
        int n = 0;
        int chunk;
        if (op <= 5 && line >= NI) begin
            errq.push_back(acc);
            return;
        end
        if (op <= 5) begin
            for (int k = 0; k < 4; k++) begin
                chunk = (line >> (2 * k)) & 3;
                if (!m_valid || chunk != ((m_line >> (2 * k)) & 3)) begin
                    push_byte(acc + n, (k << 6) | (chunk << 4) | 1);
                    n++;
                end
            end
            m_line  = line;
            m_valid = 1'b1;
        end
        case (op)
            0: push_byte(acc + n, 0);
            1, 2: begin
                for (int k = 0; k < 4; k++) begin
                    push_byte(acc + n, ((op == 2) ? 128 : 0) | (((val >> (3 * k)) & 7) << 4) | 4 | k);
                    n++;
                end
            end
            3: push_byte(acc + n, ((val & 15) << 4) | 9);
            4: push_byte(acc + n, ((val & 15) << 4) | 12);
            5: push_byte(acc + n, ((val & 15) << 4) | 2);
            6: push_byte(acc + n, ((val & 15) << 4) | 8);
            default: push_byte(acc + n, ((val & 1) << 4) | 13);
        endcase
    endtask

    // Present a request (caller is at posedge+1), wait for acceptance, record expectations.
    task automatic send(input int op, input int line, input int val, input bit keep, output int acc);
        int budget = 0;
        req_op    = 3'(op);
        req_line  = 8'(line);
        req_value = 12'(val);
        req_valid = 1'b1;
        while (!req_ready && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        model(op, line, val, acc);
        if (!keep) begin
            req_valid = 1'b0;
            req_op    = 3'($urandom);
            req_line  = 8'($urandom);
            req_value = 12'($urandom);
        end
    endtask

    // Assert reset away from the clock edge, check forced outputs, release after two edges.
    task automatic reset_pulse();
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_cmd", 32'(cmd), 32'(NOP));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        expq.delete();
        errq.delete();
        m_line  = 0;
        m_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare every cycle's outputs against the front of the expectation queues.
    always @(negedge clk) begin
        bit exp_busy;
        bit exp_err;
        if (rst_n) begin
            exp_busy = 1'b0;
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                check("byte_cycle", 32'(cyc), 32'(expq[0].cyc));
                void'(expq.pop_front());
            end
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                check("cmd_byte", 32'(cmd), 32'(expq[0].b));
                void'(expq.pop_front());
                exp_busy = 1'b1;
            end else begin
                check("cmd_idle", 32'(cmd), 32'(NOP));
            end
            check("busy", 32'(busy), 32'(exp_busy));
            check("req_ready", 32'(req_ready), 32'(!exp_busy));
            while (errq.size() > 0 && errq[0] < cyc) begin
                check("err_cycle", 32'(cyc), 32'(errq[0]));
                void'(errq.pop_front());
            end
            exp_err = (errq.size() > 0 && errq[0] == cyc);
            if (exp_err) void'(errq.pop_front());
            check("err", 32'(err), 32'(exp_err));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int a, a1, a2, a3;
        int op, line, val;
        bit keep;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("init_cmd", 32'(cmd), 32'(NOP));
        check("init_busy", 32'(busy), 32'd0);
        check("init_ready", 32'(req_ready), 32'd1);
        check("init_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed walk through line reuse, partial line update and a bad line.
        send(3, 5, 'hA, 1'b0, a);
        send(1, 5, 'hFAC, 1'b0, a);
        send(2, 6, 'h001, 1'b0, a);
        send(4, 9, 'h3, 1'b0, a);
        check("bad_line_ready", 32'(req_ready), 32'd1);
        send(3, 6, 'h5, 1'b0, a);

        // Reset in the middle of a sequence, then fresh requests.
        reset_pulse();
        send(1, 3, 'h2D7, 1'b0, a);
        @(posedge clk);
        #1;
        reset_pulse();
        send(7, 0, 1, 1'b0, a);
        send(0, 0, 'h123, 1'b0, a);

        // Valid held high through single-byte requests.
        send(6, 0, 'h5, 1'b1, a1);
        send(7, 0, 'h1, 1'b1, a2);
        send(6, 200, 'hA, 1'b0, a3);
        check("spacing_1", 32'(a2 - a1), 32'd2);
        check("spacing_2", 32'(a3 - a2), 32'd2);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 7);
            case ($urandom_range(0, 5))
                0:       line = $urandom_range(NI, 255);
                1, 2:    line = $urandom_range(0, 3);
                default: line = $urandom_range(0, NI - 1);
            endcase
            val  = $urandom;
            keep = 1'($urandom_range(0, 1));
            send(op, line, val, keep, a);
            if ($urandom_range(0, 30) == 0) begin
                reset_pulse();
            end else if (!keep) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        req_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("bytes_drained", 32'(expq.size()), 32'd0);
        check("errs_drained", 32'(errq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
